fetcher_icache: RTL
===================

Name: fetcher_icache

Overview:
- Instruction fetch stage of a compute core, directly upstream of the core scheduler.
- When the scheduler enters FETCH, the block returns the 16-bit instruction at current_pc and signals completion through fetcher_state. The scheduler advances to DECODE on fetcher_state == FETCHED.
- A small direct-mapped instruction cache sits in front of the program-memory read channel. Repeated loop bodies hit in one cycle instead of waiting on the memory controller.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8, width of PC and program-memory address.
- PROGRAM_MEM_DATA_BITS, 16, instruction width.
- CACHE_LINES, 8, number of one-instruction lines; power of two, 1..2^PROGRAM_MEM_ADDR_BITS.
- STAT_BITS, 16, width of the hit/miss counters.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- core_state  in  3  scheduler state (FETCH=3'b001, DECODE=3'b010).
- current_pc  in  PROGRAM_MEM_ADDR_BITS  PC to fetch.
- cache_invalidate  in  1  clear all cache valid bits (new kernel loaded).
- mem_read_valid  out  1  program-memory read request.
- mem_read_address  out  PROGRAM_MEM_ADDR_BITS  request address.
- mem_read_ready  in  1  memory response strobe, data valid this cycle.
- mem_read_data  in  PROGRAM_MEM_DATA_BITS  response data.
- fetcher_state  out  3  IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010.
- instruction  out  PROGRAM_MEM_DATA_BITS  fetched instruction, stable while FETCHED.
- hit_count  out  STAT_BITS  saturating cache-hit counter.
- miss_count  out  STAT_BITS  saturating cache-miss counter.

Behaviour:
- Reset (async, any state) sets:
  - fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, hit_count=0, miss_count=0.
  - All cache valid bits cleared. Tag/data arrays need not be reset.
- Address split: index = current_pc[log2(CACHE_LINES)-1:0], tag = remaining upper bits. CACHE_LINES=1 means zero index bits and a full-width tag.
- IDLE, core_state==FETCH, hit (valid & tag match):
  - instruction <= line data, fetcher_state <= FETCHED, hit_count++.
  - Latency: FETCHED visible 1 cycle after FETCH is first sampled.
- IDLE, core_state==FETCH, miss:
  - mem_read_valid <= 1, mem_read_address <= current_pc, fetcher_state <= FETCHING, miss_count++.
- FETCHING:
  - mem_read_valid and mem_read_address are held stable until mem_read_ready is sampled high.
  - On ready: instruction <= mem_read_data; line[index] <= {valid=1, tag, data}; mem_read_valid <= 0; fetcher_state <= FETCHED.
  - Miss latency = 2 + memory wait cycles (minimum 2 when ready arrives the cycle after valid).
- mem_read_ready while mem_read_valid=0 is ignored.
- FETCHED:
  - instruction is held.
  - Return to IDLE when core_state==DECODE. Any other core_state stays in FETCHED.
- core_state leaving FETCH mid-FETCHING does not abort the fetch. The outstanding request completes and the block enters FETCHED.
- cache_invalidate clears all valid bits next edge, in any state.
  - Same-cycle fill: invalidate wins (line stays invalid) but instruction is still delivered.
  - Same-cycle lookup in IDLE: the lookup sees the pre-invalidate valid bits.
- Counters saturate at all-ones; no wrap.
- Single outstanding request only. No prefetch.
- Program memory is read-only during a kernel, so no coherence handling is required beyond cache_invalidate.

Decomposition:
- Shared package core_pkg:
  - fetcher_state_t enum (IDLE/FETCHING/FETCHED).
  - core_state_t enum (IDLE..DONE, 3'b000..3'b111), shared with the scheduler.
  - Default address/data width constants.
- Sub-module icache_array:
  - Valid/tag/data storage.
  - Combinational lookup port (index, tag -> hit, data).
  - Registered write port.
  - Global invalidate.
- The fetch FSM and counters stay in fetcher_icache.

Test Plan:
- Cold miss: reset, core_state=FETCH, pc=0x05, memory answers ready 3 cycles after valid with 0xA123 -> valid=1 with addr=0x05 held until ready; FETCHED with instruction=0xA123; miss_count=1.
- Hit: after the above, DECODE then FETCH again at pc=0x05 -> no mem_read_valid; FETCHED 1 cycle later with 0xA123; hit_count=1.
- Conflict: CACHE_LINES=8, fetch 0x05 then 0x0D (same index, different tag) then 0x05 -> three misses, miss_count=3, correct data each time.
- Invalidate: fill 0x05, pulse cache_invalidate, fetch 0x05 -> miss, memory request issued. Repeat with invalidate on the ready cycle -> instruction delivered but the next fetch of the same PC misses.
- Handshake: hold FETCHED with core_state=FETCH for 5 cycles -> instruction stable, no new request; DECODE -> IDLE next cycle.
- Async reset asserted mid-FETCHING (between clock edges) -> mem_read_valid=0 and fetcher_state=IDLE immediately; counters 0; subsequent fetch of a previously cached PC misses.

Source files
------------

// File: rtl/core_pkg.sv
// Types shared between the core scheduler and the instruction fetch stage.
package core_pkg;

  localparam int DEFAULT_ADDR_BITS = 8;
  localparam int DEFAULT_DATA_BITS = 16;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_t;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction line store: same-cycle lookup, fill and invalidate on the next edge.
// No backpressure; a same-edge invalidate beats a fill, so the filled line stays invalid.
module icache_array #(
  parameter int IDX_W  = 3,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              invalidate,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int DEPTH = 1 << IDX_W;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  logic [DEPTH-1:0] valid;
  line_t            lines [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (invalidate) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data are only trusted behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lines[wr_index] <= '{tag: wr_tag, data: wr_data};
    end
  end

  assign rd_hit  = valid[rd_index] && (lines[rd_index].tag == rd_tag);
  assign rd_data = lines[rd_index].data;

endmodule

// File: rtl/fetcher_icache.sv
// Cached instruction fetch: hit returns FETCHED after 1 cycle, miss after 2 + memory wait cycles.
// One outstanding read held until mem_read_ready; FETCHED is held until the scheduler enters DECODE.
module fetcher_icache
  import core_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int PROGRAM_MEM_DATA_BITS = DEFAULT_DATA_BITS,
  parameter int CACHE_LINES           = 8,
  parameter int STAT_BITS             = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             cache_invalidate,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [STAT_BITS-1:0]             hit_count,
  output logic [STAT_BITS-1:0]             miss_count
);

  localparam int AW       = PROGRAM_MEM_ADDR_BITS;
  localparam int IDX_BITS = $clog2(CACHE_LINES);
  localparam int IDX_W    = (IDX_BITS == 0) ? 1 : IDX_BITS;
  localparam int TAG_BITS = AW - IDX_BITS;
  localparam int TAG_W    = (TAG_BITS == 0) ? 1 : TAG_BITS;
  localparam logic [AW-1:0] IDX_MASK = AW'(CACHE_LINES - 1);

  fetcher_state_t state_q, state_d;
  core_state_t    cs;

  logic                             rd_vld_d;
  logic [AW-1:0]                    addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_d;
  logic [STAT_BITS-1:0]             hit_d, miss_d;
  logic                             fill;

  logic [IDX_W-1:0]                 lk_index, fill_index;
  logic [TAG_W-1:0]                 lk_tag, fill_tag;
  logic                             lk_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] lk_data;

  assign cs = core_state_t'(core_state);

  // Fills use the held request address so a PC change mid-miss cannot corrupt the line.
  assign lk_index   = IDX_W'(current_pc & IDX_MASK);
  assign lk_tag     = TAG_W'(current_pc >> IDX_BITS);
  assign fill_index = IDX_W'(mem_read_address & IDX_MASK);
  assign fill_tag   = TAG_W'(mem_read_address >> IDX_BITS);

  icache_array #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (PROGRAM_MEM_DATA_BITS)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .invalidate (cache_invalidate),
    .rd_index   (lk_index),
    .rd_tag     (lk_tag),
    .rd_hit     (lk_hit),
    .rd_data    (lk_data),
    .wr_en      (fill),
    .wr_index   (fill_index),
    .wr_tag     (fill_tag),
    .wr_data    (mem_read_data)
  );

  always_comb begin
    state_d  = state_q;
    rd_vld_d = mem_read_valid;
    addr_d   = mem_read_address;
    instr_d  = instruction;
    hit_d    = hit_count;
    miss_d   = miss_count;
    fill     = 1'b0;
    case (state_q)
      FETCHER_IDLE: begin
        if (cs == CORE_FETCH) begin
          if (lk_hit) begin
            instr_d = lk_data;
            state_d = FETCHER_FETCHED;
            if (hit_count != '1) hit_d = hit_count + STAT_BITS'(1);
          end else begin
            rd_vld_d = 1'b1;
            addr_d   = current_pc;
            state_d  = FETCHER_FETCHING;
            if (miss_count != '1) miss_d = miss_count + STAT_BITS'(1);
          end
        end
      end
      FETCHER_FETCHING: begin
        if (mem_read_ready) begin
          instr_d  = mem_read_data;
          fill     = 1'b1;
          rd_vld_d = 1'b0;
          state_d  = FETCHER_FETCHED;
        end
      end
      FETCHER_FETCHED: begin
        if (cs == CORE_DECODE) state_d = FETCHER_IDLE;
      end
      default: state_d = FETCHER_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= FETCHER_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
    end else begin
      state_q          <= state_d;
      mem_read_valid   <= rd_vld_d;
      mem_read_address <= addr_d;
      instruction      <= instr_d;
      hit_count        <= hit_d;
      miss_count       <= miss_d;
    end
  end

  assign fetcher_state = state_q;

endmodule
